// File: rtl/idli_pkg.sv
// Shared types and helpers for the idli SQI instruction-fetch path.
// Holds the fetch FSM encoding, the SQI opcode/phase lengths and the address nibble mux.
package idli_pkg;

    typedef logic [1:0]  ctr_t;
    typedef logic [15:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        GAP
    } fetch_state_t;

    localparam logic [7:0] SQI_CMD_READ      = 8'h03;
    localparam int         SQI_ADDR_NIBBLES  = 6;
    localparam int         SQI_DUMMY_NIBBLES = 2;

    // The memory is byte addressed, so the word pc is shifted left once and
    // zero-extended to 24 bits before being sent MSB nibble first.
    function automatic logic [3:0] sqi_addr_nibble(input data_t pc, input logic [2:0] idx);
        logic [23:0] addr;
        addr = {7'b0, pc, 1'b0};
        case (idx)
            3'd0:    return addr[23:20];
            3'd1:    return addr[19:16];
            3'd2:    return addr[15:12];
            3'd3:    return addr[11:8];
            3'd4:    return addr[7:4];
            3'd5:    return addr[3:0];
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/idli_sqi_fetch_m.sv
// SQI fetch sequencer: read command, address, dummy, then one nibble per GCK, first word 14 cycles after IDLE.
// No backpressure: the stream never stalls; redirects and fetch-disable act only at word boundaries or outside DATA.
module idli_sqi_fetch_m
    import idli_pkg::*;
#(
    parameter logic [7:0] CMD_READ      = SQI_CMD_READ,
    parameter int         DUMMY_NIBBLES = SQI_DUMMY_NIBBLES
) (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst_n,
    input  logic        i_sqi_en,
    input  logic        i_sqi_redirect,
    input  logic [15:0] i_sqi_redirect_addr,
    input  logic [3:0]  i_sqi_sio,
    output logic [3:0]  o_sqi_sio,
    output logic        o_sqi_sio_oe,
    output logic        o_sqi_cs_n,
    output logic [1:0]  o_sqi_ctr,
    output logic        o_sqi_enc_vld,
    output logic [15:0] o_sqi_pc
);

    localparam logic [2:0] LP_ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
    localparam logic [2:0] LP_DUMMY_LAST = 3'(DUMMY_NIBBLES - 1);

    fetch_state_t r_state;
    logic [2:0]   r_nib;
    data_t        r_pc;
    data_t        r_redir_addr;
    logic         r_redir_pend;
    ctr_t         r_ctr;
    logic         r_cs_n;
    logic         r_oe;
    logic [3:0]   r_sio;

    logic  w_redir;
    data_t w_redir_addr;
    logic  w_boundary;
    logic  w_to_gap;
    logic  w_unused_sio;

    // A pulse arriving this cycle counts as pending and supersedes any older target.
    assign w_redir      = i_sqi_redirect | r_redir_pend;
    assign w_redir_addr = i_sqi_redirect ? i_sqi_redirect_addr : r_redir_addr;
    assign w_boundary   = (r_state == DATA) && (r_ctr == 2'd3);
    assign w_to_gap     = w_redir && ((r_state == CMD) || (r_state == ADDR) ||
                                      (r_state == DUMMY) || w_boundary);

    // Data nibbles are captured by decode straight from the pad.
    assign w_unused_sio = ^i_sqi_sio;

    always_ff @(posedge i_sqi_gck) begin
        if (!i_sqi_rst_n) begin
            r_state      <= IDLE;
            r_nib        <= 3'd0;
            r_pc         <= 16'h0000;
            r_redir_addr <= 16'h0000;
            r_redir_pend <= 1'b0;
            r_ctr        <= 2'd0;
            r_cs_n       <= 1'b1;
            r_oe         <= 1'b0;
            r_sio        <= 4'h0;
        end else begin
            r_redir_pend <= w_redir;
            if (i_sqi_redirect) begin
                r_redir_addr <= i_sqi_redirect_addr;
            end

            if (w_to_gap) begin
                r_state      <= GAP;
                r_nib        <= 3'd0;
                r_pc         <= w_redir_addr;
                r_redir_pend <= 1'b0;
                r_ctr        <= 2'd0;
                r_cs_n       <= 1'b1;
                r_oe         <= 1'b0;
                r_sio        <= 4'h0;
            end else begin
                case (r_state)
                    IDLE, GAP: begin
                        if (w_redir) begin
                            r_pc         <= w_redir_addr;
                            r_redir_pend <= 1'b0;
                        end
                        r_nib <= 3'd0;
                        r_ctr <= 2'd0;
                        if (i_sqi_en) begin
                            r_state <= CMD;
                            r_cs_n  <= 1'b0;
                            r_oe    <= 1'b1;
                            r_sio   <= CMD_READ[7:4];
                        end else begin
                            r_state <= IDLE;
                            r_cs_n  <= 1'b1;
                            r_oe    <= 1'b0;
                            r_sio   <= 4'h0;
                        end
                    end
                    CMD: begin
                        if (r_nib == 3'd0) begin
                            r_nib <= 3'd1;
                            r_sio <= CMD_READ[3:0];
                        end else begin
                            r_state <= ADDR;
                            r_nib   <= 3'd0;
                            r_sio   <= sqi_addr_nibble(r_pc, 3'd0);
                        end
                    end
                    ADDR: begin
                        if (r_nib == LP_ADDR_LAST) begin
                            r_state <= DUMMY;
                            r_nib   <= 3'd0;
                            r_oe    <= 1'b0;
                            r_sio   <= 4'h0;
                            r_ctr   <= (LP_DUMMY_LAST == 3'd0) ? 2'd3 : 2'd0;
                        end else begin
                            r_nib <= r_nib + 3'd1;
                            r_sio <= sqi_addr_nibble(r_pc, r_nib + 3'd1);
                        end
                    end
                    DUMMY: begin
                        // ctr reads 3 in the last dummy cycle so decode sees a wrap into the first nibble.
                        if (r_nib == LP_DUMMY_LAST) begin
                            r_state <= DATA;
                            r_ctr   <= 2'd0;
                        end else begin
                            r_nib <= r_nib + 3'd1;
                            r_ctr <= (r_nib + 3'd1 == LP_DUMMY_LAST) ? 2'd3 : 2'd0;
                        end
                    end
                    DATA: begin
                        r_ctr <= r_ctr + 2'd1;
                        if (r_ctr == 2'd3) begin
                            r_pc <= r_pc + 16'd1;
                            if (!i_sqi_en) begin
                                r_state <= IDLE;
                                r_cs_n  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_nib   <= 3'd0;
                        r_ctr   <= 2'd0;
                        r_cs_n  <= 1'b1;
                        r_oe    <= 1'b0;
                        r_sio   <= 4'h0;
                    end
                endcase
            end
        end
    end

    assign o_sqi_sio     = r_sio;
    assign o_sqi_sio_oe  = r_oe;
    assign o_sqi_cs_n    = r_cs_n;
    assign o_sqi_ctr     = r_ctr;
    assign o_sqi_pc      = r_pc;
    assign o_sqi_enc_vld = w_boundary && !w_redir;

endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// Bench for idli_sqi_fetch_m: an SQI memory slave plus directed scenarios and a randomized run
// checked against a transaction-level model of expected word addresses and valid timing.
module tb_idli_sqi_fetch_m;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        redir = 1'b0;
    logic [15:0] redir_addr = 16'h0000;
    logic [3:0]  sio_in = 4'h0;
    logic [3:0]  sio_out;
    logic        sio_oe;
    logic        cs_n;
    logic [1:0]  ctr;
    logic        enc_vld;
    logic [15:0] pc;

    int errors = 0;
    int checks = 0;

    idli_sqi_fetch_m dut (
        .i_sqi_gck           (clk),
        .i_sqi_rst_n         (rst_n),
        .i_sqi_en            (en),
        .i_sqi_redirect      (redir),
        .i_sqi_redirect_addr (redir_addr),
        .i_sqi_sio           (sio_in),
        .o_sqi_sio           (sio_out),
        .o_sqi_sio_oe        (sio_oe),
        .o_sqi_cs_n          (cs_n),
        .o_sqi_ctr           (ctr),
        .o_sqi_enc_vld       (enc_vld),
        .o_sqi_pc            (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        if (a == 16'h0001) return 16'hABCD;
        return {a[7:0] ^ 8'hC3, a[15:8] + 8'h5A};
    endfunction

    // SQI memory slave: counts nibble cycles since CS fell, captures command and
    // address, then streams words MSB nibble first from the captured address.
    int          s_cnt = 0;
    logic        s_low = 1'b0;
    logic [7:0]  s_cmd = 8'h00;
    logic [23:0] s_addr = 24'h0;
    logic [15:0] s_word = 16'h0;
    int          s_oe_bad = 0;

    always @(posedge clk) begin
        logic [15:0] w;
        #1;
        if (cs_n) begin
            s_low  = 1'b0;
            s_cnt  = 0;
            sio_in = 4'h0;
        end else begin
            s_cnt = s_low ? s_cnt + 1 : 0;
            s_low = 1'b1;
            if (sio_oe !== (s_cnt < 8)) s_oe_bad++;
            if (s_cnt < 2) s_cmd = {s_cmd[3:0], sio_out};
            else if (s_cnt < 8) s_addr = {s_addr[19:0], sio_out};
            if (s_cnt >= 10) begin
                s_word = s_addr[16:1] + 16'((s_cnt - 10) / 4);
                w      = mem_word(s_word);
                sio_in = 4'(w >> (12 - 4 * ((s_cnt - 10) % 4)));
            end else begin
                sio_in = 4'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; en = 1'b0; redir = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; redir = 1'b1; redir_addr = 16'h5555;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (cs_n !== 1'b1)    begin errors++; $display("FAIL reset_cs_n got=%0b exp=1", cs_n); end
        checks++; if (sio_oe !== 1'b0)  begin errors++; $display("FAIL reset_oe got=%0b exp=0", sio_oe); end
        checks++; if (sio_out !== 4'h0) begin errors++; $display("FAIL reset_sio got=%0h exp=0", sio_out); end
        checks++; if (ctr !== 2'd0)     begin errors++; $display("FAIL reset_ctr got=%0d exp=0", ctr); end
        checks++; if (enc_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%0b exp=0", enc_vld); end
        checks++; if (pc !== 16'h0000)  begin errors++; $display("FAIL reset_pc got=%0h exp=0", pc); end
        tick();
        redir = 1'b0; en = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] acc;
        do_reset();
        en = 1'b1; acc = 16'h0;
        for (int c = 0; c <= 19; c++) begin
            @(negedge clk);
            acc = {acc[11:0], sio_in};
            checks++; if (cs_n !== (c == 0)) begin errors++; $display("FAIL basic_cs_n c=%0d got=%0b", c, cs_n); end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (sio_out !== ((c == 2) ? 4'h3 : 4'h0) || sio_oe !== 1'b1) begin
                    errors++; $display("FAIL basic_sio c=%0d got=%0h oe=%0b", c, sio_out, sio_oe);
                end
            end
            if (c == 10 || c == 11) begin
                checks++; if (ctr !== ((c == 10) ? 2'd3 : 2'd0)) begin errors++; $display("FAIL basic_ctr c=%0d got=%0d", c, ctr); end
            end
            checks++; if (enc_vld !== (c == 14 || c == 18)) begin errors++; $display("FAIL basic_vld c=%0d got=%0b", c, enc_vld); end
            if (c == 14 || c == 18) begin
                checks++;
                if (pc !== ((c == 14) ? 16'h0000 : 16'h0001) || acc !== ((c == 14) ? 16'h1234 : 16'hABCD)) begin
                    errors++; $display("FAIL basic_word c=%0d pc=%0h data=%0h", c, pc, acc);
                end
            end
            tick();
        end
        checks++; if (s_cmd !== 8'h03) begin errors++; $display("FAIL basic_cmd got=%0h exp=03", s_cmd); end
    endtask

    task automatic test_redirect_data();
        logic [15:0] acc;
        do_reset();
        en = 1'b1; acc = 16'h0;
        for (int c = 0; c <= 34; c++) begin
            redir = (c == 16); redir_addr = 16'h0100;
            @(negedge clk);
            acc = {acc[11:0], sio_in};
            checks++; if (enc_vld !== (c == 14 || c == 33)) begin errors++; $display("FAIL rdata_vld c=%0d got=%0b", c, enc_vld); end
            if (c >= 17 && c <= 21) begin
                checks++; if (cs_n !== (c == 19)) begin errors++; $display("FAIL rdata_cs_n c=%0d got=%0b", c, cs_n); end
            end
            if (c >= 22 && c <= 27) begin
                checks++; if (sio_out !== ((c == 25) ? 4'h2 : 4'h0)) begin errors++; $display("FAIL rdata_addr c=%0d got=%0h", c, sio_out); end
            end
            if (c == 33) begin
                checks++; if (pc !== 16'h0100 || acc !== mem_word(16'h0100)) begin errors++; $display("FAIL rdata_word pc=%0h data=%0h", pc, acc); end
            end
            tick();
        end
        redir = 1'b0;
    endtask

    task automatic test_redirect_gap();
        logic [15:0] acc;
        do_reset();
        en = 1'b1; acc = 16'h0;
        for (int c = 0; c <= 22; c++) begin
            redir = (c == 6 || c == 7); redir_addr = (c == 6) ? 16'h1111 : 16'h2222;
            @(negedge clk);
            acc = {acc[11:0], sio_in};
            if (c >= 5 && c <= 9) begin
                checks++; if (cs_n !== (c == 7)) begin errors++; $display("FAIL rgap_cs_n c=%0d got=%0b", c, cs_n); end
            end
            if (c >= 10 && c <= 15) begin
                checks++; if (sio_out !== ((c >= 12) ? 4'h4 : 4'h0)) begin errors++; $display("FAIL rgap_addr c=%0d got=%0h", c, sio_out); end
            end
            checks++; if (enc_vld !== (c == 21)) begin errors++; $display("FAIL rgap_vld c=%0d got=%0b", c, enc_vld); end
            if (c == 21) begin
                checks++; if (pc !== 16'h2222 || acc !== mem_word(16'h2222)) begin errors++; $display("FAIL rgap_word pc=%0h data=%0h", pc, acc); end
            end
            tick();
        end
        redir = 1'b0;
    endtask

    task automatic test_pc_wrap();
        logic [15:0] acc;
        logic [23:0] ea;
        do_reset();
        en = 1'b1; acc = 16'h0; ea = 24'h01FFFE;
        for (int c = 0; c <= 19; c++) begin
            redir = (c == 0); redir_addr = 16'hFFFF;
            @(negedge clk);
            acc = {acc[11:0], sio_in};
            if (c >= 3 && c <= 8) begin
                checks++; if (sio_out !== 4'(ea >> (4 * (8 - c)))) begin errors++; $display("FAIL wrap_addr c=%0d got=%0h", c, sio_out); end
            end
            if (c >= 11) begin
                checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL wrap_cs_n c=%0d got=%0b exp=0", c, cs_n); end
            end
            checks++; if (enc_vld !== (c == 14 || c == 18)) begin errors++; $display("FAIL wrap_vld c=%0d got=%0b", c, enc_vld); end
            if (c == 14) begin
                checks++; if (pc !== 16'hFFFF || acc !== mem_word(16'hFFFF)) begin errors++; $display("FAIL wrap_word0 pc=%0h data=%0h", pc, acc); end
            end
            if (c == 15 || c == 18) begin
                checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc c=%0d got=%0h exp=0", c, pc); end
            end
            if (c == 18) begin
                checks++; if (acc !== 16'h1234) begin errors++; $display("FAIL wrap_word1 got=%0h exp=1234", acc); end
            end
            tick();
        end
        redir = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        for (int c = 0; c <= 12; c++) tick();
        rst_n = 1'b0; redir = 1'b1; redir_addr = 16'h7777;
        @(negedge clk);
        checks++; if (ctr !== 2'd2) begin errors++; $display("FAIL rmid_ctr_pre got=%0d exp=2", ctr); end
        tick();
        rst_n = 1'b1; redir = 1'b0;
        for (int c = 14; c <= 28; c++) begin
            @(negedge clk);
            if (c == 14) begin
                checks++;
                if (cs_n !== 1'b1 || ctr !== 2'd0 || enc_vld !== 1'b0 || pc !== 16'h0000 || sio_oe !== 1'b0) begin
                    errors++; $display("FAIL rmid_state cs_n=%0b ctr=%0d vld=%0b pc=%0h oe=%0b", cs_n, ctr, enc_vld, pc, sio_oe);
                end
            end
            checks++; if (enc_vld !== (c == 28)) begin errors++; $display("FAIL rmid_vld c=%0d got=%0b", c, enc_vld); end
            if (c == 28) begin
                checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rmid_pc got=%0h exp=0", pc); end
            end
            tick();
        end
    endtask

    task automatic test_en_drop();
        int nv;
        do_reset();
        nv = 0;
        for (int c = 0; c <= 26; c++) begin
            en = (c < 4);
            @(negedge clk);
            if (enc_vld) nv++;
            checks++; if (enc_vld !== (c == 14)) begin errors++; $display("FAIL endrop_vld c=%0d got=%0b", c, enc_vld); end
            if (c >= 15) begin
                checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL endrop_cs_n c=%0d got=%0b exp=1", c, cs_n); end
            end
            tick();
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL endrop_count got=%0d exp=1", nv); end
    endtask

    task automatic test_random();
        logic [15:0] acc, m_next;
        logic        m_pend, prev_cs, exp_vld, exp_stop, at_bnd;
        logic [1:0]  exp_ctr;
        int          nvld;
        do_reset();
        acc = 16'h0; m_next = 16'h0; m_pend = 1'b0; prev_cs = 1'b1; exp_stop = 1'b0; nvld = 0;
        s_oe_bad = 0;
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            redir = ($urandom_range(0, 29) == 0);
            if (redir) redir_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            @(negedge clk);
            acc = {acc[11:0], sio_in};
            // A new transaction starting after a redirect means the redirect has been taken.
            if (!cs_n && prev_cs) m_pend = 1'b0;
            if (redir) begin m_pend = 1'b1; m_next = redir_addr; end
            at_bnd  = !cs_n && s_cnt >= 13 && ((s_cnt - 13) % 4 == 0);
            exp_vld = at_bnd && !m_pend;
            exp_ctr = cs_n ? 2'd0 : (s_cnt >= 10) ? 2'((s_cnt - 10) % 4) : (s_cnt == 9) ? 2'd3 : 2'd0;
            checks++; if (enc_vld !== exp_vld) begin errors++; $display("FAIL rand_vld c=%0d got=%0b exp=%0b", c, enc_vld, exp_vld); end
            checks++; if (ctr !== exp_ctr) begin errors++; $display("FAIL rand_ctr c=%0d got=%0d exp=%0d", c, ctr, exp_ctr); end
            if (exp_stop) begin
                checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rand_stop c=%0d cs_n=%0b exp=1", c, cs_n); end
            end
            if (enc_vld && exp_vld) begin
                checks++;
                if (pc !== m_next || acc !== mem_word(m_next) || s_word !== m_next) begin
                    errors++; $display("FAIL rand_word c=%0d pc=%0h mem_addr=%0h data=%0h exp_addr=%0h", c, pc, s_word, acc, m_next);
                end
                m_next = m_next + 16'd1;
                nvld++;
            end
            exp_stop = at_bnd && (!en || m_pend);
            prev_cs  = cs_n;
            tick();
        end
        redir = 1'b0;
        checks++; if (nvld < 100) begin errors++; $display("FAIL rand_activity got=%0d exp>=100", nvld); end
        checks++; if (s_oe_bad != 0) begin errors++; $display("FAIL rand_oe got=%0d exp=0", s_oe_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_redirect_data();
        test_redirect_gap();
        test_pc_wrap();
        test_reset_mid();
        test_en_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
